// File: rtl/pu_ib_arb_pkg.sv
// Shared types and helpers for the input-buffer SRAM arbiter.
package pu_ib_arb_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RD_WAIT = 2'd1,
        WR_WAIT = 2'd2
    } arb_state_e;

    // Byte address of a channel word: tile base + channel line + word offset,
    // wrapping naturally at 2^32.
    function automatic logic [31:0] compose_addr(
        input logic [31:0] base,
        input logic [31:0] ch,
        input logic [31:0] word,
        input logic [31:0] stride
    );
        return base + (ch * stride) + (word << 2);
    endfunction

endpackage

// File: rtl/pu_rr_picker.sv
// Combinational round-robin pick: first set request at or after ptr, cyclic.
module pu_rr_picker #(
    parameter int NUM_CH = 16,
    parameter int PTR_W  = $clog2(NUM_CH)
) (
    input  logic [NUM_CH-1:0] req,
    input  logic [PTR_W-1:0]  ptr,
    output logic              valid,
    output logic [PTR_W-1:0]  idx
);

    logic [PTR_W-1:0] cand;

    // Walk offsets from farthest to nearest so the nearest set bit wins;
    // the index sum wraps because NUM_CH is a power of two.
    always_comb begin
        valid = |req;
        idx   = '0;
        cand  = '0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            cand = ptr + PTR_W'(i);
            if (req[cand]) begin
                idx = cand;
            end
        end
    end

endmodule

// File: rtl/pu_ib_sram_arbiter.sv
// Input-buffer SRAM arbiter: round-robin channel reads, loader writes with
// read/write alternation under contention.
// Optional feature macro: PU_IB_ARB_PERF_CNT_EN enables the perf counters;
// without it the counter ports read as zero.
module pu_ib_sram_arbiter
    import pu_ib_arb_pkg::*;
#(
    parameter int NUM_CH     = 16,
    parameter int DATA_W     = 256,
    parameter int LINE_BYTES = 256
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic [31:0]            base_address,
    input  logic [NUM_CH-1:0]      rd_req,
    input  logic [NUM_CH-1:0][31:0] rd_word,
    output logic [NUM_CH-1:0]      rd_ready,
    output logic [DATA_W-1:0]      rd_data,
    input  logic                   ld_wr_req,
    input  logic [31:0]            ld_wr_address,
    input  logic [DATA_W-1:0]      ld_wr_data,
    output logic                   ld_wr_ack,
    output logic                   sram_read,
    output logic                   sram_write,
    output logic [31:0]            sram_address,
    output logic [DATA_W-1:0]      sram_wdata,
    input  logic [DATA_W-1:0]      sram_rdata,
    input  logic                   sram_ready,
    output logic [31:0]            perf_read_cnt,
    output logic [31:0]            perf_write_cnt,
    output logic [31:0]            perf_stall_cnt
);

    localparam int CH_W = $clog2(NUM_CH);

    arb_state_e        state_q, state_d;
    logic [CH_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic [CH_W-1:0]   ch_q, ch_d;
    logic              wr_last_q, wr_last_d;
    logic              sram_read_q, sram_read_d;
    logic              sram_write_q, sram_write_d;
    logic [31:0]       sram_address_q, sram_address_d;
    logic [DATA_W-1:0] sram_wdata_q, sram_wdata_d;
    logic [DATA_W-1:0] rd_data_q, rd_data_d;
    logic [NUM_CH-1:0] rd_ready_q, rd_ready_d;
    logic              ld_wr_ack_q, ld_wr_ack_d;

    logic              pick_valid;
    logic [CH_W-1:0]   pick_idx;

    pu_rr_picker #(
        .NUM_CH (NUM_CH),
        .PTR_W  (CH_W)
    ) u_picker (
        .req   (rd_req),
        .ptr   (rr_ptr_q),
        .valid (pick_valid),
        .idx   (pick_idx)
    );

    // Next-state and output logic; completion pulses default low each cycle.
    always_comb begin
        state_d        = state_q;
        rr_ptr_d       = rr_ptr_q;
        ch_d           = ch_q;
        wr_last_d      = wr_last_q;
        sram_read_d    = sram_read_q;
        sram_write_d   = sram_write_q;
        sram_address_d = sram_address_q;
        sram_wdata_d   = sram_wdata_q;
        rd_data_d      = rd_data_q;
        rd_ready_d     = '0;
        ld_wr_ack_d    = 1'b0;
        case (state_q)
            IDLE: begin
                sram_read_d  = 1'b0;
                sram_write_d = 1'b0;
                // A write yields to pending reads only if it went last.
                if (ld_wr_req && (!wr_last_q || !(|rd_req))) begin
                    state_d        = WR_WAIT;
                    sram_address_d = ld_wr_address;
                    sram_wdata_d   = ld_wr_data;
                    sram_write_d   = 1'b1;
                    wr_last_d      = 1'b1;
                end else if (pick_valid) begin
                    state_d        = RD_WAIT;
                    ch_d           = pick_idx;
                    sram_address_d = compose_addr(base_address, 32'(pick_idx),
                                                  rd_word[pick_idx], 32'(LINE_BYTES));
                    sram_read_d    = 1'b1;
                    wr_last_d      = 1'b0;
                end
            end
            RD_WAIT: begin
                if (sram_ready) begin
                    rd_data_d        = sram_rdata;
                    rd_ready_d[ch_q] = 1'b1;
                    sram_read_d      = 1'b0;
                    rr_ptr_d         = ch_q + CH_W'(1);
                    state_d          = IDLE;
                end
            end
            WR_WAIT: begin
                if (sram_ready) begin
                    ld_wr_ack_d  = 1'b1;
                    sram_write_d = 1'b0;
                    state_d      = IDLE;
                end
            end
            default: begin
                state_d      = IDLE;
                sram_read_d  = 1'b0;
                sram_write_d = 1'b0;
            end
        endcase
    end

    // State and output registers; reset abandons any outstanding access.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q        <= IDLE;
            rr_ptr_q       <= '0;
            ch_q           <= '0;
            wr_last_q      <= 1'b0;
            sram_read_q    <= 1'b0;
            sram_write_q   <= 1'b0;
            sram_address_q <= '0;
            sram_wdata_q   <= '0;
            rd_data_q      <= '0;
            rd_ready_q     <= '0;
            ld_wr_ack_q    <= 1'b0;
        end else begin
            state_q        <= state_d;
            rr_ptr_q       <= rr_ptr_d;
            ch_q           <= ch_d;
            wr_last_q      <= wr_last_d;
            sram_read_q    <= sram_read_d;
            sram_write_q   <= sram_write_d;
            sram_address_q <= sram_address_d;
            sram_wdata_q   <= sram_wdata_d;
            rd_data_q      <= rd_data_d;
            rd_ready_q     <= rd_ready_d;
            ld_wr_ack_q    <= ld_wr_ack_d;
        end
    end

    assign rd_ready     = rd_ready_q;
    assign rd_data      = rd_data_q;
    assign ld_wr_ack    = ld_wr_ack_q;
    assign sram_read    = sram_read_q;
    assign sram_write   = sram_write_q;
    assign sram_address = sram_address_q;
    assign sram_wdata   = sram_wdata_q;

`ifdef PU_IB_ARB_PERF_CNT_EN
    logic [31:0] rd_cnt_q, rd_cnt_d;
    logic [31:0] wr_cnt_q, wr_cnt_d;
    logic [31:0] st_cnt_q, st_cnt_d;

    // Saturating event counters for completions and wait-state stalls.
    always_comb begin
        rd_cnt_d = rd_cnt_q;
        wr_cnt_d = wr_cnt_q;
        st_cnt_d = st_cnt_q;
        if (state_q == RD_WAIT && sram_ready && rd_cnt_q != '1) begin
            rd_cnt_d = rd_cnt_q + 32'd1;
        end
        if (state_q == WR_WAIT && sram_ready && wr_cnt_q != '1) begin
            wr_cnt_d = wr_cnt_q + 32'd1;
        end
        if (state_q != IDLE && !sram_ready && st_cnt_q != '1) begin
            st_cnt_d = st_cnt_q + 32'd1;
        end
    end

    // Counter registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            rd_cnt_q <= '0;
            wr_cnt_q <= '0;
            st_cnt_q <= '0;
        end else begin
            rd_cnt_q <= rd_cnt_d;
            wr_cnt_q <= wr_cnt_d;
            st_cnt_q <= st_cnt_d;
        end
    end

    assign perf_read_cnt  = rd_cnt_q;
    assign perf_write_cnt = wr_cnt_q;
    assign perf_stall_cnt = st_cnt_q;
`else
    assign perf_read_cnt  = 32'd0;
    assign perf_write_cnt = 32'd0;
    assign perf_stall_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_pu_ib_sram_arbiter.sv
// Randomized and directed bench for pu_ib_sram_arbiter with a transaction-level
// reference model of the arbitration rules.
module tb_pu_ib_sram_arbiter;

    localparam int NCH = 16;
    localparam int DW  = 256;
    localparam int LB  = 256;

    logic                  clock = 1'b0;
    logic                  reset;
    logic [31:0]           base_address;
    logic [NCH-1:0]        rd_req;
    logic [NCH-1:0][31:0]  rd_word;
    logic [NCH-1:0]        rd_ready;
    logic [DW-1:0]         rd_data;
    logic                  ld_wr_req;
    logic [31:0]           ld_wr_address;
    logic [DW-1:0]         ld_wr_data;
    logic                  ld_wr_ack;
    logic                  sram_read, sram_write;
    logic [31:0]           sram_address;
    logic [DW-1:0]         sram_wdata, sram_rdata;
    logic                  sram_ready;
    logic [31:0]           perf_read_cnt, perf_write_cnt, perf_stall_cnt;

    pu_ib_sram_arbiter #(.NUM_CH(NCH), .DATA_W(DW), .LINE_BYTES(LB)) dut (
        .clock(clock), .reset(reset), .base_address(base_address),
        .rd_req(rd_req), .rd_word(rd_word), .rd_ready(rd_ready), .rd_data(rd_data),
        .ld_wr_req(ld_wr_req), .ld_wr_address(ld_wr_address), .ld_wr_data(ld_wr_data),
        .ld_wr_ack(ld_wr_ack), .sram_read(sram_read), .sram_write(sram_write),
        .sram_address(sram_address), .sram_wdata(sram_wdata), .sram_rdata(sram_rdata),
        .sram_ready(sram_ready), .perf_read_cnt(perf_read_cnt),
        .perf_write_cnt(perf_write_cnt), .perf_stall_cnt(perf_stall_cnt)
    );

    always #5 clock = ~clock;

    int n_chk = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // Reference model state: busy 0=none, 1=read, 2=write.
    int busy = 0, m_ch = 0, m_rr = 0;
    bit m_wlast = 0;
    logic [31:0] e_addr = '0;
    logic [DW-1:0] e_wdata = '0, e_rdata = '0;
    logic [NCH-1:0] e_rdy;
    bit e_ack;
    int c_rd = 0, c_wr = 0, c_st = 0;
    int lat = 1, wcnt = 0;
    bit rand_lat = 0, idle_noise = 0, hold_req = 0, hold_ld = 0;
    bit p_rd = 0, p_wr = 0;
    logic [31:0] dut_addr_q[$];
    int dut_kind_q[$];

    function automatic logic [DW-1:0] rnd_word();
        return {$urandom(), $urandom(), $urandom(), $urandom(),
                $urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    function automatic int first_pick(input logic [NCH-1:0] r, input int p);
        for (int o = 0; o < NCH; o++) begin
            if (r[(p + o) % NCH]) return (p + o) % NCH;
        end
        return 0;
    endfunction

    // One clock: step the model with the inputs seen at the edge, compare,
    // then play the SRAM and requesters for the next edge.
    task automatic cycle();
        bit started;
        @(posedge clock);
        #1;
        started = 0;
        e_rdy = '0;
        e_ack = 0;
        if (reset) begin
            busy = 0; m_rr = 0; m_wlast = 0; e_rdata = '0;
            c_rd = 0; c_wr = 0; c_st = 0;
            chk("rst_addr", sram_address, 0);
            chk("rst_wdata", sram_wdata, 0);
        end else if (busy == 0) begin
            if (ld_wr_req && (!m_wlast || rd_req == 0)) begin
                busy = 2; e_addr = ld_wr_address; e_wdata = ld_wr_data; m_wlast = 1;
                started = 1;
            end else if (rd_req != 0) begin
                m_ch = first_pick(rd_req, m_rr);
                busy = 1; m_wlast = 0; started = 1;
                e_addr = base_address + 32'(m_ch * LB) + rd_word[m_ch] * 32'd4;
            end
        end else if (sram_ready) begin
            if (busy == 1) begin
                e_rdy[m_ch] = 1'b1; e_rdata = sram_rdata; m_rr = (m_ch + 1) % NCH; c_rd++;
            end else begin
                e_ack = 1; c_wr++;
            end
            busy = 0;
        end else begin
            c_st++;
        end

        chk("sram_read", sram_read, busy == 1);
        chk("sram_write", sram_write, busy == 2);
        chk("rd_ready", rd_ready, e_rdy);
        chk("ld_wr_ack", ld_wr_ack, e_ack);
        chk("rd_data", rd_data, e_rdata);
        if (busy != 0) chk("sram_address", sram_address, e_addr);
        if (busy == 2) chk("sram_wdata", sram_wdata, e_wdata);
`ifdef PU_IB_ARB_PERF_CNT_EN
        chk("perf_rd", perf_read_cnt, c_rd);
        chk("perf_wr", perf_write_cnt, c_wr);
        chk("perf_st", perf_stall_cnt, c_st);
`else
        chk("perf_rd", perf_read_cnt, 0);
        chk("perf_wr", perf_write_cnt, 0);
        chk("perf_st", perf_stall_cnt, 0);
`endif
        if ((sram_read || sram_write) && !(p_rd || p_wr)) begin
            dut_addr_q.push_back(sram_address);
            dut_kind_q.push_back(int'(sram_write));
        end
        p_rd = sram_read;
        p_wr = sram_write;

        if (started) begin
            wcnt = 0;
            if (rand_lat) lat = $urandom_range(1, 4);
        end
        if (busy != 0 && !reset) begin
            sram_ready = (wcnt + 1 >= lat);
            wcnt++;
        end else begin
            sram_ready = idle_noise ? ($urandom_range(0, 3) == 0) : 1'b0;
        end
        sram_rdata = rnd_word();

        for (int i = 0; i < NCH; i++) begin
            if (e_rdy[i] && !hold_req) rd_req[i] = 1'b0;
        end
        if (e_ack && !hold_ld) ld_wr_req = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        cycle();
        reset = 1'b0;
    endtask

    task automatic drain(input string tag);
        int n;
        n = 0;
        while (!(rd_req == 0 && ld_wr_req == 0 && busy == 0) && n < 200) begin
            cycle();
            n++;
        end
        chk(tag, n < 200, 1);
    endtask

    initial begin
        logic [31:0] a0;
        int n;
        reset = 1'b1; base_address = '0; rd_req = '0; rd_word = '0;
        ld_wr_req = 1'b0; ld_wr_address = '0; ld_wr_data = '0;
        sram_ready = 1'b0; sram_rdata = '0;
        cycle();
        cycle();
        reset = 1'b0;

        // Single read, minimum latency.
        base_address = 32'h1000; rd_word[0] = 32'd3; rd_req = 16'h0001;
        cycle();
        chk("t1_addr", sram_address, 32'h100C);
        cycle();
        chk("t1_rdy", rd_ready, 16'h0001);
        chk("t1_data", rd_data, e_rdata);
        drain("t1_drain");

        // Round-robin order across all channels from pointer 0.
        do_reset();
        for (int i = 0; i < NCH; i++) rd_word[i] = $urandom_range(0, 63);
        dut_addr_q.delete();
        hold_req = 1; rd_req = '1; n = 0;
        while (!(dut_addr_q.size() >= 17 && busy == 0) && n < 300) begin
            cycle();
            n++;
        end
        chk("t2_done", n < 300, 1);
        rd_req = '0; hold_req = 0;
        for (int i = 0; i < 17 && i < dut_addr_q.size(); i++)
            chk("t2_order", dut_addr_q[i],
                32'h1000 + 32'((i % NCH) * LB) + rd_word[i % NCH] * 32'd4);
        chk("t2_ch5", dut_addr_q[5], 32'h1000 + 32'h500 + (rd_word[5] << 2));

        // Sustained write and read ch2 contention alternates.
        dut_kind_q.delete(); dut_addr_q.delete();
        ld_wr_address = $urandom(); ld_wr_data = rnd_word();
        hold_req = 1; hold_ld = 1; rd_req = 16'h0004; ld_wr_req = 1'b1; n = 0;
        while (!(dut_kind_q.size() >= 6 && busy == 0) && n < 300) begin
            cycle();
            n++;
        end
        chk("t3_done", n < 300, 1);
        rd_req = '0; ld_wr_req = 1'b0; hold_req = 0; hold_ld = 0;
        for (int i = 0; i < 6 && i < dut_kind_q.size(); i++) begin
            chk("t3_kind", dut_kind_q[i], (i % 2 == 0) ? 1 : 0);
            if (i % 2 == 1)
                chk("t3_ch2", dut_addr_q[i], 32'h1000 + 32'h200 + rd_word[2] * 32'd4);
        end
        drain("t3_drain");

        // Five-cycle stall holds the read steady.
        do_reset();
        lat = 6; rd_word[3] = 32'd7; rd_req = 16'h0008;
        cycle();
        a0 = sram_address;
        chk("t4_addr", a0, 32'h1000 + 32'h300 + 32'd28);
        for (int i = 0; i < 5; i++) begin
            cycle();
            chk("t4_hold_rd", sram_read, 1);
            chk("t4_hold_addr", sram_address, a0);
            chk("t4_no_rdy", rd_ready, 0);
        end
        cycle();
        chk("t4_rdy", rd_ready, 16'h0008);
`ifdef PU_IB_ARB_PERF_CNT_EN
        chk("t4_stall", perf_stall_cnt, 5);
`else
        chk("t4_stall", perf_stall_cnt, 0);
`endif
        drain("t4_drain");

        // Reset in RD_WAIT, late ready ignored, pointer restarts at 0.
        rd_req = 16'h0080;
        cycle();
        cycle();
        reset = 1'b1; rd_req = '0;
        cycle();
        reset = 1'b0;
        sram_ready = 1'b1;
        cycle();
        chk("t5_no_rdy", rd_ready, 0);
        chk("t5_no_rd", sram_read, 0);
        lat = 1; base_address = 32'h2000; rd_word[0] = 32'd5; rd_req = 16'h8001;
        cycle();
        chk("t5_ch0", sram_address, 32'h2014);
        drain("t5_drain");

        // Address wraps modulo 2^32.
        base_address = 32'hFFFF_FF00; rd_word[1] = 32'h40; rd_req = 16'h0002;
        cycle();
        chk("t6_wrap", sram_address, 32'h0000_0100);
        drain("t6_drain");

        // Randomized traffic under the requester rules.
        rand_lat = 1; idle_noise = 1;
        for (int c = 0; c < 2500; c++) begin
            for (int i = 0; i < NCH; i++) begin
                if (!(busy == 1 && m_ch == i) && $urandom_range(0, 7) == 0) begin
                    if (rd_req[i]) rd_req[i] = 1'b0;
                    else begin
                        rd_word[i] = $urandom_range(0, 255);
                        rd_req[i] = 1'b1;
                    end
                end
            end
            if (busy != 2 && $urandom_range(0, 5) == 0) begin
                if (ld_wr_req) ld_wr_req = 1'b0;
                else begin
                    ld_wr_address = $urandom(); ld_wr_data = rnd_word(); ld_wr_req = 1'b1;
                end
            end
            if ($urandom_range(0, 63) == 0) base_address = $urandom();
            if ($urandom_range(0, 299) == 0) begin
                reset = 1'b1; rd_req = '0; ld_wr_req = 1'b0;
                cycle();
                reset = 1'b0;
            end else begin
                cycle();
            end
        end
        rd_req = '0; ld_wr_req = 1'b0; rand_lat = 0; lat = 1; idle_noise = 0;
        drain("rand_drain");

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
